// File: rtl/mig_seq_evaluator.sv
// Programmable majority-inverter-graph evaluator: one MAJ node per clock,
// either for a single input vector or swept over every minterm.
module mig_seq_evaluator #(
    parameter int N_IN    = 7,
    parameter int N_NODES = 8,
    localparam int SEL_W  = $clog2(1 + N_IN + N_NODES),
    localparam int AW     = $clog2(N_NODES),
    localparam int LW     = $clog2(N_NODES + 1),
    localparam int PW     = 3 * (SEL_W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            prog_we,
    input  logic [AW-1:0]   prog_addr,
    input  logic [PW-1:0]   prog_data,
    input  logic            start,
    input  logic            mode,
    input  logic [LW-1:0]   len,
    input  logic [N_IN-1:0] in_vec,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_bit,
    output logic [N_IN-1:0] res_idx,
    output logic            res_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       prog_q [N_NODES];
    logic [PW-1:0]       prog_d [N_NODES];
    logic [N_NODES-1:0]  node_q, node_d;
    logic                mode_q, mode_d;
    logic [LW-1:0]       len_q, len_d;
    logic [LW-1:0]       k_q, k_d;
    logic [N_IN-1:0]     x_q, x_d;
    logic                busy_q, busy_d;
    logic                res_valid_q, res_valid_d;
    logic                res_bit_q, res_bit_d;
    logic                res_last_q, res_last_d;

    logic [PW-1:0]       entry;
    logic                op_a, op_b, op_c;
    logic                node_new;
    logic                eval_last;
    logic                run_last;

    // Operand fetch: constant 0, a primary input, or a node register.
    // Select codes past the last node fall through to 0.
    function automatic logic pick(input logic               inv,
                                  input logic [SEL_W-1:0]   sel,
                                  input logic [N_IN-1:0]    x,
                                  input logic [N_NODES-1:0] nodes);
        logic v;
        v = 1'b0;
        for (int i = 0; i < N_IN; i++)
            if (sel == SEL_W'(i + 1)) v = x[i];
        for (int k = 0; k < N_NODES; k++)
            if (sel == SEL_W'(N_IN + 1 + k)) v = nodes[k];
        return v ^ inv;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (l > LW'(N_NODES)) ? LW'(N_NODES) : l;
    endfunction

    assign entry     = prog_q[k_q[AW-1:0]];
    assign op_a      = pick(entry[PW-1], entry[PW-2 -: SEL_W], x_q, node_q);
    assign op_b      = pick(entry[2*(SEL_W+1)-1], entry[2*(SEL_W+1)-2 -: SEL_W], x_q, node_q);
    assign op_c      = pick(entry[SEL_W], entry[SEL_W-1:0], x_q, node_q);
    assign node_new  = maj3(op_a, op_b, op_c);
    // A zero-length program still spends one EVAL cycle.
    assign eval_last = (len_q == '0) || (k_q == len_q - LW'(1));
    assign run_last  = !mode_q || (&x_q);

    always_comb begin
        state_d     = state_q;
        prog_d      = prog_q;
        node_d      = node_q;
        mode_d      = mode_q;
        len_d       = len_q;
        k_d         = k_q;
        x_d         = x_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        res_bit_d   = res_bit_q;
        res_last_d  = res_last_q;

        if (prog_we && !busy_q)
            prog_d[prog_addr] = prog_data;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = clamp_len(len);
                    x_d     = mode ? '0 : in_vec;
                    node_d  = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (len_q != '0)
                    node_d[k_q[AW-1:0]] = node_new;
                if (eval_last) begin
                    res_valid_d = 1'b1;
                    res_bit_d   = (len_q == '0) ? 1'b0 : node_new;
                    res_last_d  = run_last;
                    state_d     = S_OUT;
                end else begin
                    k_d = k_q + LW'(1);
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_bit_d   = 1'b0;
                    res_last_d  = 1'b0;
                    if (run_last) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // Next minterm starts from cleared nodes so that
                        // forward references never see the previous minterm.
                        x_d     = x_q + N_IN'(1);
                        node_d  = '0;
                        k_d     = '0;
                        state_d = S_EVAL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < N_NODES; i++)
                prog_q[i] <= '0;
            node_q      <= '0;
            mode_q      <= 1'b0;
            len_q       <= '0;
            k_q         <= '0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_bit_q   <= 1'b0;
            res_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prog_q      <= prog_d;
            node_q      <= node_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            k_q         <= k_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_bit_q   <= res_bit_d;
            res_last_q  <= res_last_d;
        end
    end

    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_bit   = res_bit_q;
    assign res_idx   = x_q;
    assign res_last  = res_last_q;

endmodule
